// File: rtl/d_ff_pipe.sv
// Stallable pipeline register: DEPTH handshaked stages with per-stage valid
// bits. Bubbles collapse toward the output, flush clears the valid bits, and
// an occupancy counter tracks the number of valid stages.

// One pipeline stage: a data register plus its valid flag.
module d_ff_pipe_stage #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,    // capture din, stage becomes valid
  input  logic [WIDTH-1:0] din,
  input  logic             unload,  // current item leaves this stage
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Data is only written on a load; the valid flag follows load/unload/flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else begin
      if (load) d <= din;
      if (flush)       v <= 1'b0;
      else if (load)   v <= 1'b1;
      else if (unload) v <= 1'b0;
    end
  end

endmodule

module d_ff_pipe #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            mv;
  logic [DEPTH-1:0]            load;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0][WIDTH-1:0] din;
  logic                        acc0;
  logic                        accept;
  logic                        xfer;

  // Movement, evaluated from the output end: a stage advances when the stage
  // ahead can take it, and a stage can take an item when it is empty or its
  // own item is leaving. Carrying that "can take" as a running scalar keeps
  // the chain free of self-referencing vectors.
  always_comb begin
    logic run;
    run = out_ready;
    mv  = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      mv[k] = v[k] & run;
      run   = ~v[k] | run;
    end
    acc0 = run;
  end

  assign in_ready  = acc0 & ~flush;
  assign accept    = in_valid & in_ready;
  assign xfer      = v[DEPTH-1] & out_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Stage 0 is fed from the input port; every other stage from its neighbour.
  // Internal shifts are suppressed during flush so data registers stay put.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign load[k] = accept;
      assign din[k]  = in_data;
    end else begin : g_body
      assign load[k] = mv[k-1] & ~flush;
      assign din[k]  = d[k-1];
    end

    d_ff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .load   (load[k]),
      .din    (din[k]),
      .unload (mv[k]),
      .v      (v[k]),
      .d      (d[k])
    );
  end

  // Occupancy: +1 per accept, -1 per output transfer; flush empties it.
  always_ff @(posedge clk) begin
    if (!rst_n)     count <= '0;
    else if (flush) count <= '0;
    else            count <= count + CW'(accept) - CW'(xfer);
  end

endmodule

// File: tb/tb_d_ff_pipe.sv
// Bench for d_ff_pipe: two instances (8-bit x 4 deep, reset A5; 1-bit x 1
// deep) share stimulus; the selected one is compared each cycle against a
// queue-based model that tracks each in-flight item and its stage position.
module tb_d_ff_pipe;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, out_ready, flush;
  logic [7:0] in_data;

  logic       a_ir, a_ov;
  logic [7:0] a_od;
  logic [2:0] a_cnt;
  logic       b_ir, b_ov;
  logic [0:0] b_od;
  logic [0:0] b_cnt;

  d_ff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_ir), .out_valid(a_ov), .out_data(a_od),
    .out_ready(out_ready), .flush(flush), .count(a_cnt));

  d_ff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data[0:0]),
    .in_ready(b_ir), .out_valid(b_ov), .out_data(b_od),
    .out_ready(out_ready), .flush(flush), .count(b_cnt));

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] d;
    int         p;
  } item_t;

  item_t      mq[$];
  int         mdep;
  logic [7:0] mmask;
  logic [7:0] m_rv;
  logic [7:0] m_last;   // value held by the output-side data register
  bit         sel;

  function automatic logic m_ir();
    return !flush && (out_ready || mq.size() < mdep);
  endfunction

  function automatic logic m_ov();
    return mq.size() > 0 && mq[0].p == mdep - 1;
  endfunction

  function automatic logic [13:0] m_outs();
    return {m_ir(), m_ov(), m_last, 4'(mq.size())};
  endfunction

  function automatic logic [13:0] dut_outs();
    if (sel) return {b_ir, b_ov, 7'b0, b_od, 3'b0, b_cnt};
    return {a_ir, a_ov, a_od, 1'b0, a_cnt};
  endfunction

  function automatic logic o_ir();  logic [13:0] o = dut_outs(); return o[13];       endfunction
  function automatic logic o_ov();  logic [13:0] o = dut_outs(); return o[12];       endfunction
  function automatic logic [7:0] o_od(); logic [13:0] o = dut_outs(); return o[11:4]; endfunction
  function automatic int o_cnt();   logic [13:0] o = dut_outs(); return int'(o[3:0]); endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic rdy, ov;
    int   lim, np;
    rdy = m_ir();
    ov  = m_ov();
    if (!rst_n) begin
      mq.delete();
      m_last = m_rv;
      return;
    end
    if (ov && out_ready) void'(mq.pop_front());
    if (flush) begin
      mq.delete();
      return;
    end
    lim = mdep;
    for (int i = 0; i < mq.size(); i++) begin
      np = mq[i].p + 1;
      if (np > lim - 1) np = lim - 1;
      if (np == mdep - 1 && mq[i].p != mdep - 1) m_last = mq[i].d;
      mq[i].p = np;
      lim = np;
    end
    if (in_valid && rdy) begin
      mq.push_back(item_t'{d: in_data & mmask, p: 0});
      if (mdep == 1) m_last = in_data & mmask;
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0); tick();
    drive(0, 8'h00, 0, 0); tick();
    rst_n = 1'b1;
    drive(0, 8'h00, 0, 0);
    nchk++; if (o_ov() !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", o_ov()); else npass++;
    nchk++; if (o_od() !== m_rv) $display("FAIL reset_out_data got %h exp %h", o_od(), m_rv); else npass++;
    nchk++; if (o_cnt() !== 0) $display("FAIL reset_count got %0d exp 0", o_cnt()); else npass++;
    nchk++; if (o_ir() !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", o_ir()); else npass++;
    tick();
  endtask

  task automatic test_stream();
    int sent = 1;
    int peak = 0;
    for (int c = 0; c < 40; c++) begin
      drive(sent <= 16, 8'(sent), 1'b1, 1'b0);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL stream c%0d got %h exp %h", c, dut_outs(), m_outs()); else npass++;
      if (o_cnt() > peak) peak = o_cnt();
      if (in_valid && m_ir()) sent++;
      tick();
    end
    nchk++; if (peak !== mdep) $display("FAIL stream_peak_count got %0d exp %0d", peak, mdep); else npass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] nd;
    int         exp2;
    drive(1, 8'h11, 0, 0);
    nchk++; if (dut_outs() !== m_outs()) $display("FAIL bp_first got %h exp %h", dut_outs(), m_outs()); else npass++;
    tick();
    repeat (3) begin
      drive(0, 8'h00, 0, 0);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL bp_gap got %h exp %h", dut_outs(), m_outs()); else npass++;
      tick();
    end
    drive(m_ir(), 8'h22, 0, 0);
    nchk++; if (dut_outs() !== m_outs()) $display("FAIL bp_second got %h exp %h", dut_outs(), m_outs()); else npass++;
    tick();
    repeat (mdep + 1) begin
      drive(0, 8'h00, 0, 0);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL bp_settle got %h exp %h", dut_outs(), m_outs()); else npass++;
      tick();
    end
    exp2 = (mdep < 2) ? mdep : 2;
    drive(0, 8'h00, 0, 0);
    nchk++; if (o_cnt() !== exp2) $display("FAIL bp_packed_count got %0d exp %0d", o_cnt(), exp2); else npass++;
    nchk++; if (o_ov() !== 1'b1 || o_od() !== (8'h11 & mmask)) $display("FAIL bp_packed_head got %b/%h exp 1/%h", o_ov(), o_od(), 8'h11 & mmask); else npass++;
    tick();
    nd = 8'h33;
    for (int c = 0; c < 20 && m_ir(); c++) begin
      drive(1, nd, 0, 0);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL bp_fill c%0d got %h exp %h", c, dut_outs(), m_outs()); else npass++;
      tick();
      nd = nd + 8'h11;
    end
    drive(0, 8'h00, 0, 0);
    nchk++; if (o_ir() !== 1'b0 || o_cnt() !== mdep) $display("FAIL bp_full got ir=%b cnt=%0d exp ir=0 cnt=%0d", o_ir(), o_cnt(), mdep); else npass++;
    tick();
    for (int c = 0; c < 3 * mdep + 6; c++) begin
      drive(0, 8'h00, 1, 0);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL bp_drain c%0d got %h exp %h", c, dut_outs(), m_outs()); else npass++;
      tick();
    end
    drive(0, 8'h00, 1, 0);
    nchk++; if (o_cnt() !== 0) $display("FAIL bp_drained got %0d exp 0", o_cnt()); else npass++;
    tick();
  endtask

  task automatic test_full_pass();
    for (int c = 0; c < 20 && m_ir(); c++) begin
      drive(1, 8'($urandom), 0, 0);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL full_fill got %h exp %h", dut_outs(), m_outs()); else npass++;
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      drive(1, 8'($urandom), 1, 0);
      nchk++; if (o_ir() !== 1'b1 || o_cnt() !== mdep) $display("FAIL full_pass c%0d got ir=%b cnt=%0d exp ir=1 cnt=%0d", c, o_ir(), o_cnt(), mdep); else npass++;
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL full_pass_model c%0d got %h exp %h", c, dut_outs(), m_outs()); else npass++;
      tick();
    end
    for (int c = 0; c < mdep + 2; c++) begin
      drive(0, 8'h00, 1, 0);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL full_drain got %h exp %h", dut_outs(), m_outs()); else npass++;
      tick();
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'h40 + i), 0, 0);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL flush_fill got %h exp %h", dut_outs(), m_outs()); else npass++;
      tick();
    end
    repeat (mdep) begin
      drive(0, 8'h00, 0, 0);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL flush_settle got %h exp %h", dut_outs(), m_outs()); else npass++;
      tick();
    end
    drive(1, 8'h99, 1, 1);
    nchk++; if (o_ir() !== 1'b0 || o_ov() !== 1'b1 || o_cnt() !== 3) $display("FAIL flush_cycle got ir=%b ov=%b cnt=%0d exp ir=0 ov=1 cnt=3", o_ir(), o_ov(), o_cnt()); else npass++;
    tick();
    drive(0, 8'h00, 1, 0);
    nchk++; if (o_cnt() !== 0 || o_ov() !== 1'b0) $display("FAIL flush_after got cnt=%0d ov=%b exp cnt=0 ov=0", o_cnt(), o_ov()); else npass++;
    nchk++; if (dut_outs() !== m_outs()) $display("FAIL flush_after_model got %h exp %h", dut_outs(), m_outs()); else npass++;
    tick();
    drive(1, 8'h77, 1, 0);
    tick();
    for (int c = 0; c < mdep + 4; c++) begin
      drive(0, 8'h00, 1, 0);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL flush_new c%0d got %h exp %h", c, dut_outs(), m_outs()); else npass++;
      if (o_ov() && o_od() == 8'h77) seen++;
      tick();
    end
    nchk++; if (seen !== 1) $display("FAIL flush_new_item_count got %0d exp 1", seen); else npass++;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 20 && m_ir(); c++) begin
      drive(1, 8'(8'hC0 + c), 0, 0);
      tick();
    end
    drive(0, 8'h00, 0, 0);
    nchk++; if (o_cnt() !== mdep) $display("FAIL rstmid_full got %0d exp %0d", o_cnt(), mdep); else npass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(0, 8'h00, 1, 0);
    nchk++; if (o_cnt() !== 0 || o_ov() !== 1'b0 || o_od() !== m_rv) $display("FAIL rstmid_after got cnt=%0d ov=%b od=%h exp 0/0/%h", o_cnt(), o_ov(), o_od(), m_rv); else npass++;
    tick();
    for (int c = 0; c < mdep + 3; c++) begin
      drive(0, 8'h00, 1, 0);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL rstmid_quiet c%0d got %h exp %h", c, dut_outs(), m_outs()); else npass++;
      tick();
    end
  endtask

  task automatic test_random(input int n);
    logic       hiv = 1'b0;
    logic [7:0] hid = 8'h00;
    logic       hold = 1'b0;
    logic       ordy, fl;
    for (int c = 0; c < n; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      fl    = ($urandom_range(0, 19) == 0);
      ordy  = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        hiv = ($urandom_range(0, 2) != 0);
        hid = 8'($urandom);
      end
      drive(hiv, hid, ordy, fl);
      nchk++; if (dut_outs() !== m_outs()) $display("FAIL random c%0d got %h exp %h", c, dut_outs(), m_outs()); else npass++;
      hold = hiv && !m_ir() && rst_n;
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush = 1'b0;
    sel = 1'b0; mdep = 4; mmask = 8'hFF; m_rv = 8'hA5; m_last = 8'hA5;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pass();
    test_flush();
    test_reset_mid();
    test_random(400);

    sel = 1'b1; mdep = 1; mmask = 8'h01; m_rv = 8'h00; m_last = 8'h00;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pass();
    test_reset_mid();
    test_random(300);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

endmodule
